// File: rtl/mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mul_rr_scheduler
// Description : Round-robin scheduler that shares one combinational
//               multiplier among NREQ requesters. Registers the winning
//               operands toward the multiplier, captures the product one
//               cycle later and returns it with the requester index over a
//               valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_rr_scheduler #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_p,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_p,
    output logic                    busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [IDW-1:0] C_LAST_IDX = IDW'(NREQ - 1);

    logic [1:0]           r_state;
    logic [IDW-1:0]       r_rr_ptr;
    logic [WIDTH-1:0]     r_mul_a;
    logic [WIDTH-1:0]     r_mul_b;
    logic                 r_rsp_valid;
    logic [IDW-1:0]       r_rsp_id;
    logic [2*WIDTH-1:0]   r_rsp_p;

    logic [IDW-1:0]       w_cand [NREQ];
    logic                 w_found;
    logic [IDW-1:0]       w_winner;
    logic [IDW-1:0]       w_next_ptr;
    logic [NREQ-1:0]      w_ready;

    // Candidate requester indices in priority order, starting at the pointer.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            w_cand[k] = IDW'((int'(r_rr_ptr) + k) % NREQ);
        end
    end

    // First valid candidate wins; earlier candidates have higher priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[w_cand[k]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[k];
            end
        end
    end

    assign w_next_ptr = (w_winner == C_LAST_IDX) ? '0 : w_winner + 1'b1;

    // One-hot grant, only offered in IDLE and never while reset is asserted.
    always_comb begin
        w_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_found) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    // Control FSM: accept in IDLE, capture product in CALC, hold response in RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_p     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_mul_a  <= req_a[w_winner*WIDTH +: WIDTH];
                        r_mul_b  <= req_b[w_winner*WIDTH +: WIDTH];
                        r_rsp_id <= w_winner;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rsp_p     <= mul_p;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_ready;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_p     = r_rsp_p;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_rr_scheduler
// Description : Self-checking bench for mul_rr_scheduler. A transaction-level
//               model (pointer, phase, captured operands) predicts every
//               output each cycle; directed scenarios add explicit checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [2*WIDTH-1:0]    mul_p;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_p;
    logic                  busy;

    always #5 clk = ~clk;

    // The shared multiplier instance the scheduler drives.
    always_comb mul_p = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);

    mul_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 = waiting, 1 = computing, 2 = responding.
    int                 m_ptr;
    int                 m_phase;
    logic [WIDTH-1:0]   m_a, m_b;
    logic [IDW-1:0]     m_id;
    logic [2*WIDTH-1:0] m_p;
    int                 last_grant;
    int                 cyc = 0;
    int                 g_id[$];
    int                 g_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_a = '0; m_b = '0; m_id = '0; m_p = '0;
    endtask

    // Called at a negedge with inputs already applied; checks, advances the model, steps one clock.
    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        int w;
        #1;
        w = model_winner();
        exp_ready  = '0;
        last_grant = -1;
        if (rst_n && m_phase == 0 && w >= 0) begin
            exp_ready[w] = 1'b1;
            last_grant   = w;
        end
        chk("req_ready", req_ready, exp_ready);
        chk("rsp_valid", rsp_valid, m_phase == 2);
        chk("busy",      busy,      m_phase != 0);
        chk("mul_a",     mul_a,     m_a);
        chk("mul_b",     mul_b,     m_b);
        chk("rsp_id",    rsp_id,    m_id);
        chk("rsp_p",     rsp_p,     m_p);
        if (!rst_n) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (w >= 0) begin
                m_a     = req_a[w*WIDTH +: WIDTH];
                m_b     = req_b[w*WIDTH +: WIDTH];
                m_id    = IDW'(w);
                m_ptr   = (w + 1) % NREQ;
                m_phase = 1;
                g_id.push_back(w);
                g_cyc.push_back(cyc);
            end
        end else if (m_phase == 1) begin
            m_p     = (2*WIDTH)'(m_a) * (2*WIDTH)'(m_b);
            m_phase = 2;
        end else if (rsp_ready) begin
            m_phase = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_valid[i]             = 1'b1;
        req_a[i*WIDTH +: WIDTH]  = WIDTH'(a);
        req_b[i*WIDTH +: WIDTH]  = WIDTH'(b);
    endtask

    // One cycle; a granted requester then either drops or presents a fresh request.
    task automatic tick(input bit refresh);
        cycle();
        if (last_grant >= 0) begin
            if (refresh) set_req(last_grant, $urandom_range(0, 15), $urandom_range(0, 15));
            else         req_valid[last_grant] = 1'b0;
        end
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick(1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset state; requests present but req_ready must stay low
        cycle();
        cycle();
        rst_n     = 1'b1;
        req_valid = '0;

        // Test 1: single request from requester 0
        rsp_ready = 1'b1;
        set_req(0, 10, 15);
        #1 chk("t1_ready", req_ready, 4'b0001);
        tick(1'b0);
        tick(1'b0);
        #1;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_p", rsp_p, 150);
        chk("t1_rsp_id", rsp_id, 0);
        tick(1'b0);
        drain();

        // Test 2: all requesting continuously, response always accepted
        do_reset();
        g_id.delete(); g_cyc.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(0, 15), $urandom_range(0, 15));
        rsp_ready = 1'b1;
        repeat (14) tick(1'b1);
        chk("t2_grant_count", g_id.size() >= 5, 1);
        for (int k = 0; k < 5 && k < g_id.size(); k++) begin
            chk("t2_grant_id", g_id[k], k % NREQ);
            if (k > 0) chk("t2_grant_gap", g_cyc[k] - g_cyc[k-1], 3);
        end
        drain();

        // Test 3: pointer at 3, requesters 3 and 0 -> wrap order 3 then 0
        do_reset();
        set_req(2, 1, 2);
        tick(1'b0);
        drain();
        g_id.delete();
        set_req(3, 7, 9);
        set_req(0, 4, 6);
        for (int k = 0; k < 12 && g_id.size() < 2; k++) tick(1'b0);
        chk("t3_grant_count", g_id.size() >= 2, 1);
        if (g_id.size() >= 2) begin
            chk("t3_first", g_id[0], 3);
            chk("t3_second", g_id[1], 0);
        end
        drain();
        g_id.delete();
        set_req(0, 2, 2);
        set_req(1, 3, 3);
        tick(1'b0);
        chk("t3_ptr_after_wrap", (g_id.size() > 0) ? g_id[0] : -1, 1);
        drain();

        // Test 4: back-pressure holds the response stable
        g_id.delete();
        rsp_ready = 1'b0;
        set_req(1, 15, 15);
        tick(1'b0);
        tick(1'b0);
        set_req(0, 5, 5);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_rsp_p", rsp_p, 225);
            chk("t4_rsp_id", rsp_id, 1);
            chk("t4_req_ready", req_ready, 0);
            chk("t4_busy", busy, 1);
            tick(1'b0);
        end
        rsp_ready = 1'b1;
        tick(1'b0);
        tick(1'b0);
        drain();

        // Test 5: reset during the compute cycle drops the transaction
        set_req(2, 3, 5);
        tick(1'b0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_busy", busy, 0);
        g_id.delete();
        set_req(3, 1, 1);
        set_req(0, 2, 3);
        tick(1'b0);
        chk("t5_ptr_reset", (g_id.size() > 0) ? g_id[0] : -1, 0);
        req_valid[3] = 1'b0;
        drain();

        // Test 6: idle period leaves the pointer unchanged
        g_id.delete();
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            rsp_ready = k[0];
            tick(1'b0);
        end
        #1;
        chk("t6_req_ready", req_ready, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_no_grant", g_id.size(), 0);
        for (int i = 0; i < NREQ; i++) set_req(i, i, i + 1);
        tick(1'b0);
        chk("t6_ptr_kept", (g_id.size() > 0) ? g_id[0] : -1, 1);
        drain();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, $urandom_range(0, 15), $urandom_range(0, 15));
            end
            rsp_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) do_reset();
            else tick(1'b0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
